compare_serial: RTL and testbench
=================================

# compare_serial

Parametrised, multi-cycle magnitude comparator for the operator display datapath. Compares two WIDTH-bit operands digit-serially, most significant digit first, DIGIT bits per clock. Supports unsigned or two's-complement comparison per operation and reports a registered one-hot greater/less/equal result with a start/busy/done handshake. It replaces the single-cycle 4-bit comparator wherever wider operands, or a registered and handshaked result, are needed.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits compared per clock; NDIG = WIDTH/DIGIT digits per operation.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- en  input  1  block enable; low forces idle and clears outputs, as in the existing comparator.
- start  input  1  request a comparison; sampled only in IDLE with en=1.
- a  input  WIDTH  operand A; sampled on the accepted start edge.
- b  input  WIDTH  operand B; sampled on the accepted start edge.
- sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  3  one-hot: [2] a>b, [1] a<b, [0] a==b; 000 when no valid result.

## Operation
- States: IDLE and RUN. Digit index k counts 0..NDIG-1, with 0 = most significant digit.
- IDLE, en=1, start=1: capture a and b into shift registers.
  - If sgn=1, invert the MSB of both captured operands (offset-binary mapping); the rest of the compare is unsigned.
  - Clear result to 000, set k=0, go to RUN, busy=1.
- RUN, each edge: compare digit k of A against digit k of B.
  - Digits differ: the decision is final; A digit > B digit gives 100, otherwise 010.
  - Digits equal and k = NDIG-1: decision 001.
  - Otherwise: k increments, operands shift by DIGIT.
- On the decision edge (see Configuration for when it occurs): load result, pulse done=1 for one cycle, busy=0, go to IDLE.
- result holds its value until the next accepted start, the next en=0 cycle or reset.
- start while busy=1 is ignored. It is not queued.
- A start in the cycle where done=1 is accepted, because the state is already IDLE.
- en=0 on any edge: state IDLE, busy=0, done=0, result=000. A comparison in progress is abandoned and no done is produced.
- rst_n=0 on any edge: same as en=0, and also clears k and the operand registers. This holds mid-operation.
- rst_n has priority over en; en has priority over start.

## Timing
- Reset values: busy=0, done=0, result=000, state IDLE.
- Start edge E0 captures the operands. busy is high from the cycle after E0.
- Full-length compare: decision at edge E0+NDIG, so done is high in cycle E0+NDIG and busy is low in that same cycle.
- Early-exit compare: decision at edge E0+k+1, where k is the first differing digit.
- Back-to-back throughput: one operation per NDIG+1 cycles at worst.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro COMPARE_SERIAL_EARLY_EXIT_EN.
- Defined: the decision is taken on the first differing digit. Latency is k+1 cycles; equal operands still take NDIG cycles.
- Undefined: every operation takes exactly NDIG cycles. The first differing digit is latched internally, and later digits do not alter it.
- result values are identical in both builds; only latency differs.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- a=0x1234, b=0x1235, sgn=0, start pulse -> done 4 cycles after the start edge (both builds), result=010.
- a=0x8000, b=0x7FFF, sgn=0 -> result=100; repeat with sgn=1 -> result=010. With COMPARE_SERIAL_EARLY_EXIT_EN, done 1 cycle after start; without it, 4 cycles.
- a=b=0xABCD -> result=001, done after 4 cycles in both builds.
- start at the edge after E0 with a=0, b=0xFFFF -> ignored. The first operation completes with its own result, and exactly one done pulse occurs.
- Drop en for one cycle at E0+2 -> busy=0, result=000, no done. Then start with a=5, b=3 -> result=100.
- rst_n low for one edge at E0+1 -> all outputs 0 from the next cycle, and no done. A start held high while rst_n=0 is not accepted.

Source files
------------

// File: rtl/compare_serial.sv
// compare_serial: digit-serial magnitude comparator, MSB digit first, with a start/busy/done handshake.
// Ports: clk, rst_n (sync active-low), en (low forces idle and clears outputs),
//        start/a/b/sgn (request, operands and signed mode sampled when accepted in idle),
//        busy (compare in progress), done (one-cycle result-valid pulse), result (one-hot {gt,lt,eq}).
// Macro COMPARE_SERIAL_EARLY_EXIT_EN: decide on the first differing digit instead of always
// walking all NDIG digits.
module compare_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] sa, sb;
  logic [DIGIT-1:0] da, db;
  logic             diff, last, decide;
  logic [2:0]       cur, verdict;
  // Flipping the sign bit maps two's complement onto offset binary, so one unsigned compare serves both modes.
  logic [WIDTH-1:0] flip;
  assign flip = {sgn, {(WIDTH-1){1'b0}}};
  assign da = sa[WIDTH-1 -: DIGIT];
  assign db = sb[WIDTH-1 -: DIGIT];
  assign diff = da != db;
  assign last = k == KW'(NDIG - 1);
  assign cur = diff ? (da > db ? 3'b100 : 3'b010) : 3'b001;
  assign busy = state == RUN;
`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
  assign decide = diff | last;
  assign verdict = cur;
`else
  // The first differing digit settles the answer; later digits must not overwrite it.
  logic       found;
  logic [2:0] hit;
  assign decide = last;
  assign verdict = found ? hit : cur;
  always_ff @(posedge clk) begin
    if (!rst_n || (en && state == IDLE)) begin
      found <= 1'b0;
      hit <= 3'b000;
    end else if (en && diff && !found) begin
      found <= 1'b1;
      hit <= cur;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      result <= 3'b000;
      k <= '0;
      sa <= '0;
      sb <= '0;
    end else if (!en) begin
      state <= IDLE;
      done <= 1'b0;
      result <= 3'b000;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sa <= a ^ flip;
          sb <= b ^ flip;
          k <= '0;
          result <= 3'b000;
          state <= RUN;
        end
      end else if (decide) begin
        result <= verdict;
        done <= 1'b1;
        state <= IDLE;
      end else begin
        k <= k + 1'b1;
        sa <= sa << DIGIT;
        sb <= sb << DIGIT;
      end
    end
  end
endmodule

// File: tb/tb_compare_serial.sv
// tb_compare_serial: table-driven, hand-written and randomized checks of compare_serial (WIDTH=16, DIGIT=4).
module tb_compare_serial;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done;
  logic [2:0] result;
  int checks = 0, errors = 0;
`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  always #5 clk = ~clk;
  compare_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .a(a), .b(b), .sgn(sgn),
    .busy(busy), .done(done), .result(result)
  );
  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [2:0]  res;
    int          lat_early, lat_late;
  } vec_t;
  vec_t tv[10];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [2:0] ref_res(input logic [15:0] x, input logic [15:0] y, input logic s);
    if (s) return $signed(x) > $signed(y) ? 3'b100 : $signed(x) < $signed(y) ? 3'b010 : 3'b001;
    return x > y ? 3'b100 : x < y ? 3'b010 : 3'b001;
  endfunction
  function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
    if (!EARLY) return 4;
    for (int i = 0; i < 4; i++)
      if (((x >> (12 - 4 * i)) & 16'hF) != ((y >> (12 - 4 * i)) & 16'hF)) return i + 1;
    return 4;
  endfunction
  // Called #1 after a rising edge; the next edge is the start edge E0.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                        output logic [2:0] r, output int lat);
    a = ia; b = ib; sgn = is; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("result_cleared", result, 0);
    chk("done_one_cycle", done, 0);
    lat = 99;
    r = 3'b000;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        r = result;
        chk("busy_at_done", busy, 0);
        break;
      end
    end
  endtask
  task automatic count_done(input int n, output int cnt, output logic [2:0] r);
    cnt = 0;
    r = 3'b000;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt++;
        r = result;
      end
    end
  endtask
  initial begin
    logic [2:0] r;
    int lat, cnt;
    tv[0] = '{16'h1234, 16'h1235, 1'b0, 3'b010, 4, 4};
    tv[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1, 4};
    tv[2] = '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 1, 4};
    tv[3] = '{16'hABCD, 16'hABCD, 1'b0, 3'b001, 4, 4};
    tv[4] = '{16'hABCD, 16'hABCD, 1'b1, 3'b001, 4, 4};
    tv[5] = '{16'h0005, 16'h0003, 1'b1, 3'b100, 4, 4};
    tv[6] = '{16'h0F00, 16'h0E00, 1'b0, 3'b100, 2, 4};
    tv[7] = '{16'hFFFF, 16'h0000, 1'b1, 3'b010, 1, 4};
    tv[8] = '{16'h1200, 16'h1300, 1'b0, 3'b010, 2, 4};
    tv[9] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1, 4};
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", busy, 0);
    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].s, r, lat);
      chk($sformatf("vec%0d_result", i), r, tv[i].res);
      chk($sformatf("vec%0d_latency", i), lat, EARLY ? tv[i].lat_early : tv[i].lat_late);
    end
    chk("result_holds", result, tv[9].res);
    // start one edge into an operation is ignored
    a = 16'h1234; b = 16'h1235; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0000; b = 16'hFFFF;
    @(posedge clk); #1 start = 1'b0;
    count_done(10, cnt, r);
    chk("ignored_start_done_count", cnt, 1);
    chk("ignored_start_result", r, 3'b010);
    chk("ignored_start_idle", busy, 0);
    // en low for the edge E0+2 abandons the operation
    a = 16'hABCD; b = 16'hABCD; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1;
    chk("en_drop_busy", busy, 0);
    chk("en_drop_done", done, 0);
    chk("en_drop_result", result, 0);
    en = 1'b1;
    count_done(8, cnt, r);
    chk("en_drop_no_done", cnt, 0);
    run_op(16'd5, 16'd3, 1'b0, r, lat);
    chk("after_en_result", r, 3'b100);
    chk("after_en_latency", lat, EARLY ? 4 : 4);
    // rst_n low for the edge E0+1 with start held high
    a = 16'h1234; b = 16'h1235; start = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midop_reset_busy", busy, 0);
    chk("midop_reset_done", done, 0);
    chk("midop_reset_result", result, 0);
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("reset_start_not_accepted", busy, 0);
    count_done(8, cnt, r);
    chk("midop_reset_no_done", cnt, 0);
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      logic rs;
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom);
        1: rb = ra;
        2: rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = ra ^ 16'($urandom_range(0, 255));
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, r, lat);
      chk($sformatf("rand_result_%h_%h_%0d", ra, rb, rs), r, ref_res(ra, rb, rs));
      chk($sformatf("rand_latency_%h_%h", ra, rb), lat, ref_lat(ra, rb));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
